morse_encoder: RTL and testbench
================================

MORSE_ENCODER -- requirements
Module: morse_encoder

Interface
REQ-001 clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 char_in  input  8  ASCII character to encode; sampled only on acceptance.
REQ-004 char_valid  input  1  char_in holds a character for encoding.
REQ-005 char_ready  output  1  encoder can accept a character; acceptance = char_valid && char_ready at a posedge.
REQ-006 dot_inp  output  1  one-cycle pulse per dot element.
REQ-007 dash_inp  output  1  one-cycle pulse per dash element.
REQ-008 char_space_inp  output  1  one-cycle pulse marking end of character.
REQ-009 word_space_inp  output  1  one-cycle pulse marking word gap.
REQ-010 err  output  1  one-cycle pulse when the accepted character is unsupported.
REQ-011 busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE, SYM, CSP, WSP, ERR; char_ready SHALL be high only in IDLE.
REQ-013 On acceptance, the encoder SHALL latch code length len (1..5) and pattern (1 = dash), first element MSB-first.
REQ-014 From IDLE, acceptance SHALL move the FSM to SYM for letters and digits, WSP for 0x20, and ERR otherwise.
REQ-015 Letters A-Z and a-z SHALL encode identically, per ITU Morse.
REQ-016 In SYM, exactly one of dot_inp/dash_inp SHALL be high per cycle for len consecutive cycles, then the FSM SHALL enter CSP.
REQ-017 CSP SHALL last one cycle with char_space_inp=1, then the FSM SHALL return to IDLE.
REQ-018 WSP SHALL last one cycle with word_space_inp=1, then IDLE; ERR SHALL last one cycle with err=1, then IDLE.
REQ-019 The first output pulse SHALL occur in the cycle after the acceptance edge (latency 1).
REQ-020 At most one of dot_inp, dash_inp, char_space_inp, word_space_inp, err SHALL be high in any cycle.
REQ-021 char_valid and char_in SHALL be ignored while char_ready=0.
REQ-022 Back-to-back acceptance SHALL be allowed: a character accepted in the IDLE cycle following CSP/WSP/ERR starts immediately.
REQ-023 A character SHALL occupy len+1 cycles from first element to return to IDLE, with no idle cycles between elements.
REQ-024 The element counter SHALL be 3 bits; no wrap is possible because len is at most 5.

Reset
REQ-025 When rst=1, the FSM SHALL go to IDLE, with char_ready=1 and busy=0.
REQ-026 When rst=1, dot_inp, dash_inp, char_space_inp, word_space_inp and err SHALL all be 0.
REQ-027 When rst=1, the latched code and element counter SHALL be 0.
REQ-028 Reset mid-character SHALL discard the character; no char_space_inp SHALL follow.
REQ-029 No acceptance SHALL occur while rst=1.

Configuration
REQ-030 With macro MOR_DIGITS_EN defined, '0'-'9' SHALL encode as 5-element ITU codes.
REQ-031 Without MOR_DIGITS_EN, '0'-'9' SHALL take the ERR path, and the digit table SHALL be absent from the RTL.

Verification
REQ-032 'E' (0x45) accepted at edge N -> dot_inp at N+1, char_space_inp at N+2, char_ready=1 at N+3.
REQ-033 'q' (0x71) -> dash, dash, dot, dash at N+1..N+4, char_space_inp at N+5, and no other pulses.
REQ-034 0x20 then 'T' back-to-back -> word_space_inp at N+1, dash_inp at N+3, char_space_inp at N+4.
REQ-035 '5' (0x35) -> five dot_inp pulses then char_space_inp with MOR_DIGITS_EN; a single err pulse at N+1 without it.
REQ-036 '#' (0x23) -> err at N+1 only, with no symbol pulses.
REQ-037 rst asserted during the 2nd element of 'Q' -> all outputs 0 immediately, char_ready=1, and no char_space_inp.

Source files
------------

// File: rtl/morse_encoder.sv
// Morse encoder: accepts one ASCII character at a time and emits a stream of
// one-cycle element pulses (dot/dash), followed by a character-space pulse.
// A space character yields a single word-space pulse. An unsupported character
// yields a single err pulse.
// Outputs are decoded from the registered state, so the first pulse appears in
// the cycle after the acceptance edge.
// Optional feature: define MOR_DIGITS_EN to encode '0'-'9'. Without it, digits
// take the error path.
module morse_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       dot_inp,
    output logic       dash_inp,
    output logic       char_space_inp,
    output logic       word_space_inp,
    output logic       err,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StSym  = 3'd1,
        StCsp  = 3'd2,
        StWsp  = 3'd3,
        StErr  = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] len_q, len_d;   // number of elements in the latched code
    logic [4:0] pat_q, pat_d;   // left-aligned pattern; bit 4 is the current element
    logic [2:0] cnt_q, cnt_d;   // elements already emitted

    logic [7:0] upper;
    logic [2:0] lut_len;
    logic [4:0] lut_pat;

    // Look up a character: returns {len, left-aligned pattern}; len 0 means no code.
    function automatic logic [7:0] lookup(input logic [7:0] c);
        logic [7:0] r;
        r = 8'd0;
        case (c)
            8'h41: r = {3'd2, 5'b01000}; // A .-
            8'h42: r = {3'd4, 5'b10000}; // B -...
            8'h43: r = {3'd4, 5'b10100}; // C -.-.
            8'h44: r = {3'd3, 5'b10000}; // D -..
            8'h45: r = {3'd1, 5'b00000}; // E .
            8'h46: r = {3'd4, 5'b00100}; // F ..-.
            8'h47: r = {3'd3, 5'b11000}; // G --.
            8'h48: r = {3'd4, 5'b00000}; // H ....
            8'h49: r = {3'd2, 5'b00000}; // I ..
            8'h4A: r = {3'd4, 5'b01110}; // J .---
            8'h4B: r = {3'd3, 5'b10100}; // K -.-
            8'h4C: r = {3'd4, 5'b01000}; // L .-..
            8'h4D: r = {3'd2, 5'b11000}; // M --
            8'h4E: r = {3'd2, 5'b10000}; // N -.
            8'h4F: r = {3'd3, 5'b11100}; // O ---
            8'h50: r = {3'd4, 5'b01100}; // P .--.
            8'h51: r = {3'd4, 5'b11010}; // Q --.-
            8'h52: r = {3'd3, 5'b01000}; // R .-.
            8'h53: r = {3'd3, 5'b00000}; // S ...
            8'h54: r = {3'd1, 5'b10000}; // T -
            8'h55: r = {3'd3, 5'b00100}; // U ..-
            8'h56: r = {3'd4, 5'b00010}; // V ...-
            8'h57: r = {3'd3, 5'b01100}; // W .--
            8'h58: r = {3'd4, 5'b10010}; // X -..-
            8'h59: r = {3'd4, 5'b10110}; // Y -.--
            8'h5A: r = {3'd4, 5'b11000}; // Z --..
`ifdef MOR_DIGITS_EN
            8'h30: r = {3'd5, 5'b11111}; // 0 -----
            8'h31: r = {3'd5, 5'b01111}; // 1 .----
            8'h32: r = {3'd5, 5'b00111}; // 2 ..---
            8'h33: r = {3'd5, 5'b00011}; // 3 ...--
            8'h34: r = {3'd5, 5'b00001}; // 4 ....-
            8'h35: r = {3'd5, 5'b00000}; // 5 .....
            8'h36: r = {3'd5, 5'b10000}; // 6 -....
            8'h37: r = {3'd5, 5'b11000}; // 7 --...
            8'h38: r = {3'd5, 5'b11100}; // 8 ---..
            8'h39: r = {3'd5, 5'b11110}; // 9 ----.
`endif
            default: r = 8'd0;
        endcase
        return r;
    endfunction

    // Fold lower-case letters onto upper case, then look up the code.
    always_comb begin
        upper = char_in;
        if (char_in >= 8'h61 && char_in <= 8'h7A) begin
            upper = char_in - 8'h20;
        end
        {lut_len, lut_pat} = lookup(upper);
    end

    // State and latched-code registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= 3'd0;
            pat_q   <= 5'd0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and pulse outputs.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        pat_d          = pat_q;
        cnt_d          = cnt_q;
        char_ready     = 1'b0;
        dot_inp        = 1'b0;
        dash_inp       = 1'b0;
        char_space_inp = 1'b0;
        word_space_inp = 1'b0;
        err            = 1'b0;
        busy           = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                char_ready = 1'b1;
                if (char_valid) begin
                    if (lut_len != 3'd0) begin
                        state_d = StSym;
                        len_d   = lut_len;
                        pat_d   = lut_pat;
                        cnt_d   = 3'd0;
                    end else if (char_in == 8'h20) begin
                        state_d = StWsp;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StSym: begin
                dash_inp = pat_q[4];
                dot_inp  = ~pat_q[4];
                pat_d    = {pat_q[3:0], 1'b0};
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == len_q - 3'd1) begin
                    state_d = StCsp;
                end
            end
            StCsp: begin
                char_space_inp = 1'b1;
                state_d        = StIdle;
            end
            StWsp: begin
                word_space_inp = 1'b1;
                state_d        = StIdle;
            end
            StErr: begin
                err     = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder: a table of characters with hand-written
// expected pulse strings, plus back-to-back and mid-character reset sequences.
// Pulse string letters: '.' dot, '-' dash, 'C' char space, 'W' word space,
// 'E' err, '_' nothing, '!' more than one pulse.
module tb_morse_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic       dot_inp;
    logic       dash_inp;
    logic       char_space_inp;
    logic       word_space_inp;
    logic       err;
    logic       busy;

    int total;
    int bad;

    typedef struct {
        logic [7:0] ch;
        string      exp;
    } vec_t;

    vec_t vecs[$];

    morse_encoder dut (
        .clk           (clk),
        .rst           (rst),
        .char_in       (char_in),
        .char_valid    (char_valid),
        .char_ready    (char_ready),
        .dot_inp       (dot_inp),
        .dash_inp      (dash_inp),
        .char_space_inp(char_space_inp),
        .word_space_inp(word_space_inp),
        .err           (err),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic byte out_code();
        int n;
        byte c;
        n = int'(dot_inp) + int'(dash_inp) + int'(char_space_inp) + int'(word_space_inp)
            + int'(err);
        c = "_";
        if (n > 1) c = "!";
        else if (dot_inp) c = ".";
        else if (dash_inp) c = "-";
        else if (char_space_inp) c = "C";
        else if (word_space_inp) c = "W";
        else if (err) c = "E";
        return c;
    endfunction

    task automatic check_code(input string name, input byte got, input byte want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got '%c' want '%c'", name, got, want);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    // Called at a negedge with the encoder idle; returns at a negedge, idle again.
    task automatic run_vec(input logic [7:0] ch, input string exp);
        char_in    = ch;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        char_in    = 8'h45; // garbage while busy must be ignored
        for (int k = 0; k < exp.len(); k++) begin
            @(negedge clk);
            check_code($sformatf("chr %02h el%0d", ch, k), out_code(), exp[k]);
            check_bit($sformatf("chr %02h busy%0d", ch, k), busy, 1'b1);
            check_bit($sformatf("chr %02h rdy%0d", ch, k), char_ready, 1'b0);
        end
        @(negedge clk);
        check_code($sformatf("chr %02h end", ch), out_code(), "_");
        check_bit($sformatf("chr %02h end rdy", ch), char_ready, 1'b1);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        char_in    = 8'h00;
        char_valid = 1'b0;

        vecs.push_back('{8'h45, ".C"});     // E
        vecs.push_back('{8'h71, "--.-C"});  // q
        vecs.push_back('{8'h41, ".-C"});    // A (lowest letter)
        vecs.push_back('{8'h5A, "--..C"});  // Z (highest upper)
        vecs.push_back('{8'h61, ".-C"});    // a
        vecs.push_back('{8'h7A, "--..C"});  // z
        vecs.push_back('{8'h4B, "-.-C"});   // K
        vecs.push_back('{8'h79, "-.--C"});  // y
        vecs.push_back('{8'h48, "....C"});  // H
        vecs.push_back('{8'h6F, "---C"});   // o
        vecs.push_back('{8'h4A, ".---C"});  // J
        vecs.push_back('{8'h20, "W"});      // space
        vecs.push_back('{8'h23, "E"});      // #
        vecs.push_back('{8'h40, "E"});      // @ just below A
        vecs.push_back('{8'h5B, "E"});      // [ just above Z
        vecs.push_back('{8'h60, "E"});      // ` just below a
        vecs.push_back('{8'h7B, "E"});      // { just above z
        vecs.push_back('{8'h2F, "E"});      // / just below 0
        vecs.push_back('{8'h3A, "E"});      // : just above 9
`ifdef MOR_DIGITS_EN
        vecs.push_back('{8'h35, ".....C"});
        vecs.push_back('{8'h30, "-----C"});
        vecs.push_back('{8'h39, "----.C"});
        vecs.push_back('{8'h31, ".----C"});
`else
        vecs.push_back('{8'h35, "E"});
        vecs.push_back('{8'h30, "E"});
        vecs.push_back('{8'h39, "E"});
`endif

        // Reset state, with valid asserted to show nothing is accepted in reset.
        repeat (2) @(posedge clk);
        char_valid = 1'b1;
        char_in    = 8'h45;
        @(negedge clk);
        check_code("reset pulses", out_code(), "_");
        check_bit("reset ready", char_ready, 1'b1);
        check_bit("reset busy", busy, 1'b0);
        @(negedge clk);
        char_valid = 1'b0;
        rst        = 1'b0;
        @(negedge clk);
        check_code("post reset idle", out_code(), "_");

        foreach (vecs[i]) begin
            run_vec(vecs[i].ch, vecs[i].exp);
        end

        // Space then 'T' with valid held: T is accepted in the IDLE cycle after WSP.
        char_in    = 8'h20;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_in = 8'h54;
        @(negedge clk);
        check_code("b2b wsp", out_code(), "W");
        check_bit("b2b wsp rdy", char_ready, 1'b0);
        @(negedge clk);
        check_code("b2b idle", out_code(), "_");
        check_bit("b2b idle rdy", char_ready, 1'b1);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        @(negedge clk);
        check_code("b2b dash", out_code(), "-");
        @(negedge clk);
        check_code("b2b csp", out_code(), "C");
        @(negedge clk);
        check_code("b2b end", out_code(), "_");
        check_bit("b2b end rdy", char_ready, 1'b1);

        // 'Q' back-to-back after 'E': accepted in the IDLE cycle after CSP,
        // then reset during its second element.
        run_vec(8'h45, ".C");
        char_in    = 8'h51;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        @(negedge clk);
        check_code("rstq el0", out_code(), "-");
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_code("rstq pulses", out_code(), "_");
        check_bit("rstq ready", char_ready, 1'b1);
        check_bit("rstq busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_code($sformatf("rstq quiet%0d", k), out_code(), "_");
            check_bit($sformatf("rstq rdy%0d", k), char_ready, 1'b1);
        end

        // Encoder still works normally after the interrupted character.
        run_vec(8'h51, "--.-C");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
